fetch_unit: RTL

- Instruction fetch stage: owns the program counter and drives the combinational instruction ROM address.
- Captures the returned 32-bit word into an IF/ID output register, with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute, which flush the held instruction.
- Detects misaligned fetches and parks in a fault state until redirected.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_if_id_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   RESET_VECTOR_DEFAULT : PC after reset, also the base of the instruction ROM
//   ROM_BYTES            : size of the ROM window in bytes
//   fetch_state_e        : fetch FSM states (BOOT, RUN, FAULT)
//   fetch_fault_e        : fault cause encoding reported on fault_cause_o
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam int unsigned ROM_BYTES            = 4096;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        FF_NONE     = 2'b00,
        FF_MISALIGN = 2'b01,
        FF_BOUNDS   = 2'b10
    } fetch_fault_e;

endpackage

// File: rtl/fetch_if_id_reg.sv
// fetch_if_id_reg: IF/ID pipeline register between fetch and decode.
//
// Handshake: valid is high while the register holds an instruction; decode
// takes it on a clock edge where valid && ready. The register may load a new
// word whenever it is empty or being drained (load_en = !valid || ready), and
// its contents never change while valid && !ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             squash the held instruction (redirect), wins over load
//   capture           a new word is available this cycle
//   ready             decode accepts the held instruction
//   next_instr/pc/pc_plus4  word to capture and its addresses
//   load_en           register can accept a new word this cycle
//   valid, instr, pc, pc_plus4  registered outputs toward decode
module fetch_if_id_reg #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  capture,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] next_instr,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    input  logic [ADDR_WIDTH-1:0] next_pc_plus4,
    output logic                  load_en,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    assign load_en = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            // Payload is left as-is; only valid matters once squashed.
            valid <= 1'b0;
        end else if (load_en) begin
            // With no new word the held one has been accepted, so go empty.
            valid <= capture;
            if (capture) begin
                instr    <= next_instr;
                pc       <= next_pc;
                pc_plus4 <= next_pc_plus4;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, addresses a combinational
// instruction ROM, and hands fetched words to decode through an IF/ID
// register with a valid/ready handshake. Execute can redirect the PC, which
// squashes the held instruction and clears any fetch fault. A misaligned PC
// parks the unit in FAULT until the next redirect.
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to also fault (cause 2'b10)
// on any PC outside [RESET_VECTOR, RESET_VECTOR + ROM_BYTES - 4].
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   imem_addr_o          ROM byte address, driven straight from the PC
//   imem_data_i          ROM read data for imem_addr_o
//   redirect_i/_pc_i     PC change request and target from execute
//   out_valid_o/ready_i  handshake toward decode
//   instr_o, pc_o, pc_plus4_o  fetched instruction and its addresses
//   fault_o, fault_cause_o, fault_pc_o  fetch fault status
//   state_o              current FSM state (debug visibility)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  fault_o,
    output logic [1:0]            fault_cause_o,
    output logic [ADDR_WIDTH-1:0] fault_pc_o,
    output logic [1:0]            state_o
);

    localparam logic [1:0] ST_BOOT  = BOOT;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FAULT = FAULT;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic                  fault_q;
    logic [1:0]            cause_q;
    logic [ADDR_WIDTH-1:0] fault_pc_q;

    logic                  load_en;
    logic                  capture;
    logic                  flush;
    logic                  misaligned;
    logic                  out_of_window;
    logic [1:0]            fetch_cause;

    // Sequential PC wraps modulo 2^ADDR_WIDTH by plain truncation.
    assign pc_seq      = pc_q + PC_STEP;
    assign imem_addr_o = pc_q;
    assign misaligned  = (pc_q[1:0] != 2'b00);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(ROM_BYTES - 4);
    logic [ADDR_WIDTH-1:0] rom_offset;

    // A PC below the base wraps to a huge offset, so one unsigned compare
    // covers both ends of the window.
    assign rom_offset    = pc_q - RESET_VECTOR;
    assign out_of_window = (rom_offset > LAST_OFFSET);
`else
    assign out_of_window = 1'b0;
`endif

    // Misalignment takes priority when both conditions hold.
    always_comb begin
        fetch_cause = FF_NONE;
        if (misaligned) begin
            fetch_cause = FF_MISALIGN;
        end else if (out_of_window) begin
            fetch_cause = FF_BOUNDS;
        end
    end

    // BOOT has nothing held, so a redirect there needs no squash.
    assign flush   = redirect_i && (state_q != ST_BOOT);
    assign capture = (state_q == ST_RUN) && !redirect_i && (fetch_cause == FF_NONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            fault_q    <= 1'b0;
            cause_q    <= FF_NONE;
            fault_pc_q <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        fault_q <= 1'b0;
                        cause_q <= FF_NONE;
                    end else if (load_en) begin
                        if (fetch_cause != FF_NONE) begin
                            fault_q    <= 1'b1;
                            cause_q    <= fetch_cause;
                            fault_pc_q <= pc_q;
                            state_q    <= ST_FAULT;
                        end else begin
                            pc_q <= pc_seq;
                        end
                    end
                end
                ST_FAULT: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        fault_q <= 1'b0;
                        cause_q <= FF_NONE;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    fetch_if_id_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .flush         (flush),
        .capture       (capture),
        .ready         (out_ready_i),
        .next_instr    (imem_data_i),
        .next_pc       (pc_q),
        .next_pc_plus4 (pc_seq),
        .load_en       (load_en),
        .valid         (out_valid_o),
        .instr         (instr_o),
        .pc            (pc_o),
        .pc_plus4      (pc_plus4_o)
    );

    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_pc_o    = fault_pc_q;
    assign state_o       = state_q;

endmodule
